param_lane_packer: RTL and testbench
====================================

Name: param_lane_packer

Overview:
- Parametrised successor to the fixed 32-bit byte-write/shift register.
- Packs a stream of LANE_W-bit lanes into a LANES-wide word (first lane ends up most significant).
- Presents the word on a valid/ready port, or drains it back out lane-by-lane, MSB lane first.
- Sits between the byte-serial fetch/load path and word consumers; supports partial-word flush with zero padding.

Parameters:
- LANE_W, 8, bits per lane.
- LANES, 4, lanes per word (>=2); word width W = LANES*LANE_W.
- CNT_W, $clog2(LANES+1), width of the lane counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input lane offered.
- in_ready  out  1  lane accepted when in_valid && in_ready.
- in_data  in  LANE_W  input lane.
- flush  in  1  close a partial word (zero-pad to full width).
- word_valid  out  1  packed word available.
- word_ready  in  1  consumer takes word.
- word_data  out  W  packed word.
- word_lanes  out  CNT_W  number of real (non-pad) lanes in word_data.
- drain_req  in  1  request lane-serial drain of held word.
- lane_valid  out  1  drain lane available.
- lane_ready  in  1  drain consumer takes lane.
- lane_data  out  LANE_W  current MSB lane during drain.

Behaviour:
- State: `sreg[W-1:0]`, `cnt[CNT_W-1:0]`, FSM {FILL, FULL, DRAIN}.
- Reset (when reset=1 at posedge):
  - sreg=0, cnt=0, state=FILL.
  - Outputs: in_ready=1, word_valid=0, lane_valid=0, word_data=0, word_lanes=0, lane_data=0.
  - Reset has priority over all other inputs and aborts any fill or drain in progress.
- FILL:
  - in_ready=1.
  - On accept: sreg <= {sreg[W-LANE_W-1:0], in_data}; cnt <= cnt+1.
  - When the accepted lane makes cnt == LANES, go to FULL on the same edge; word_valid rises the next cycle (1-cycle latency from last lane).
  - flush with cnt_next = cnt + accept > 0:
    - sreg <= (shifted value) << ((LANES-cnt_next)*LANE_W); cnt <= cnt_next; go to FULL.
    - A lane accepted in the same cycle is included before padding.
  - flush with cnt_next == 0: ignored, stay in FILL.
  - drain_req, word_ready, lane_ready: ignored in FILL.
- FULL:
  - in_ready=0; word_valid=1; word_data=sreg; word_lanes=cnt.
  - word_ready=1: sreg <= 0, cnt <= 0, go to FILL.
  - Else drain_req=1: go to DRAIN.
  - Both high: word_ready wins.
  - flush ignored.
- DRAIN:
  - in_ready=0, word_valid=0, lane_valid=1, lane_data=sreg[W-1:W-LANE_W].
  - On lane_ready: sreg <= {sreg[W-LANE_W-1:0], LANE_W'b0}; cnt <= cnt-1.
  - When the lane taken is the last one (cnt==1), go to FILL with sreg=0, cnt=0.
  - Only cnt real lanes are drained; pad lanes are never emitted.
- Outputs:
  - word_data and word_lanes are driven as 0 outside FULL.
  - lane_data is 0 outside DRAIN.
- Arithmetic and timing:
  - cnt never exceeds LANES and never wraps.
  - Shift amount is computed at full width; a padding shift of 0 when cnt_next == LANES.
  - Throughput in FILL is one lane per cycle; no combinational path from word_ready/lane_ready to in_ready.

Decomposition:
- Shared package:
  - state enum {FILL, FULL, DRAIN}.
  - Default LANE_W/LANES constants.
  - A function computing the pad shift amount.
- No sub-module needed. Optionally factor a `lane_shifter` (left shift by one lane with selectable LSB fill) reused by fill and drain.

Test Plan (LANE_W=8, LANES=4):
- Full fill: lanes 0x11,0x22,0x33,0x44 on consecutive cycles, word_ready=1 -> word_valid one cycle after 4th accept, word_data=0x11223344, word_lanes=4; next cycle in_ready=1, cnt=0.
- Flush partial: lanes 0xAA,0xBB, then flush with in_valid=0 -> word_data=0xAABB0000, word_lanes=2.
- Flush with simultaneous lane: 0x01 then (in_valid=1, 0x02, flush=1) -> word_data=0x01020000, word_lanes=2.
- Backpressure and drain:
  - Fill 0xDEADBEEF; word_ready=0, drain_req=1 -> DRAIN.
  - lane_data sequence DE,AD,BE,EF, with lane_ready toggling 1/0 (each lane held stable while not taken).
  - FILL after the 4th lane.
- Partial drain: flush after 3 lanes 0x10,0x20,0x30, then drain -> exactly 3 lanes 10,20,30 emitted, then FILL.
- Reset mid-operation: assert reset during DRAIN after 1 lane -> next cycle all outputs at reset values, in_ready=1; a fresh fill 0x01020304 packs correctly. Also cover word_ready and drain_req asserted together in FULL -> word consumed, no drain.

Source files
------------

// File: rtl/param_lane_packer_pkg.sv
// Shared types and helpers for the lane packer.
// Provides the FSM state enum, default geometry and the pad-shift helper.
package param_lane_packer_pkg;

    localparam int DEF_LANE_W = 8;
    localparam int DEF_LANES  = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bits to shift a partial word left so its first lane lands on top.
    // Zero when the word is already full.
    function automatic int pad_shift(int lanes, int filled, int lane_w);
        return (lanes - filled) * lane_w;
    endfunction

endpackage

// File: rtl/param_lane_packer.sv
// Packs LANE_W-bit lanes into a LANES-wide word, first lane most significant.
// Ports: clk/reset; in_valid/in_ready/in_data lane input; flush closes a
// partial word; word_valid/word_ready/word_data/word_lanes word output;
// drain_req starts a lane-serial drain on lane_valid/lane_ready/lane_data.
module param_lane_packer
    import param_lane_packer_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W,
    parameter int LANES  = DEF_LANES,
    parameter int CNT_W  = $clog2(LANES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANE_W-1:0]        in_data,
    input  logic                     flush,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [LANES*LANE_W-1:0]  word_data,
    output logic [CNT_W-1:0]         word_lanes,
    input  logic                     drain_req,
    output logic                     lane_valid,
    input  logic                     lane_ready,
    output logic [LANE_W-1:0]        lane_data
);

    localparam int W = LANES * LANE_W;

    state_t            state, state_n;
    logic [W-1:0]      sreg, sreg_n, fill_word;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic              accept;

    assign accept    = in_valid && (state == FILL);
    assign cnt_inc   = cnt + CNT_W'(accept);
    assign fill_word = accept ? {sreg[W-LANE_W-1:0], in_data} : sreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
        end
    end

    // Outputs depend only on state/sreg/cnt, so the ready inputs never
    // reach in_ready combinationally.
    always_comb begin
        state_n    = state;
        sreg_n     = sreg;
        cnt_n      = cnt;
        in_ready   = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        word_lanes = '0;
        lane_valid = 1'b0;
        lane_data  = '0;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                sreg_n   = fill_word;
                cnt_n    = cnt_inc;
                if (cnt_inc == CNT_W'(LANES)) begin
                    state_n = FULL;
                end else if (flush && (cnt_inc != '0)) begin
                    // Lane taken this cycle is already in fill_word.
                    sreg_n  = fill_word
                              << pad_shift(LANES, int'(cnt_inc), LANE_W);
                    state_n = FULL;
                end
            end
            FULL: begin
                word_valid = 1'b1;
                word_data  = sreg;
                word_lanes = cnt;
                if (word_ready) begin
                    sreg_n  = '0;
                    cnt_n   = '0;
                    state_n = FILL;
                end else if (drain_req) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                lane_valid = 1'b1;
                lane_data  = sreg[W-1 -: LANE_W];
                if (lane_ready) begin
                    if (cnt == CNT_W'(1)) begin
                        sreg_n  = '0;
                        cnt_n   = '0;
                        state_n = FILL;
                    end else begin
                        sreg_n = {sreg[W-LANE_W-1:0], {LANE_W{1'b0}}};
                        cnt_n  = cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = FILL;
                sreg_n  = '0;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_param_lane_packer.sv
// Self-checking bench for param_lane_packer (LANE_W=8, LANES=4).
// Directed vector table, a stall/drain sequence and random cycles vs a queue model.
module tb_param_lane_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        flush = 1'b0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [31:0] word_data;
    logic [2:0]  word_lanes;
    logic        drain_req = 1'b0;
    logic        lane_valid;
    logic        lane_ready = 1'b0;
    logic [7:0]  lane_data;

    param_lane_packer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_lanes (word_lanes),
        .drain_req  (drain_req),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .lane_data  (lane_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, iv;
        logic [7:0]  d;
        logic        fl, wr, dr, lr;
        logic        ir, wv;
        logic [31:0] wd;
        logic [2:0]  wl;
        logic        lv;
        logic [7:0]  ld;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: lanes collected so far, word held, phase.
    logic [7:0] mq[$];
    logic [7:0] mh[$];
    int         mph = 0;

    function automatic vec_t mk(logic rst, logic iv, logic [7:0] d,
                                logic fl, logic wr, logic dr, logic lr,
                                logic ir, logic wv, logic [31:0] wd,
                                logic [2:0] wl, logic lv, logic [7:0] ld);
        vec_t v;
        v.rst = rst; v.iv = iv; v.d = d; v.fl = fl;
        v.wr = wr; v.dr = dr; v.lr = lr;
        v.ir = ir; v.wv = wv; v.wd = wd; v.wl = wl;
        v.lv = lv; v.ld = ld;
        return v;
    endfunction

    function automatic logic [31:0] pack_word();
        logic [31:0] w = '0;
        foreach (mh[i]) w = w | (32'(mh[i]) << (8 * (3 - i)));
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            mq.delete();
            mh.delete();
            mph = 0;
        end else if (mph == 0) begin
            if (in_valid) mq.push_back(in_data);
            if (mq.size() == 4 || (flush && mq.size() > 0)) begin
                mh = mq;
                mq.delete();
                mph = 1;
            end
        end else if (mph == 1) begin
            if (word_ready) begin
                mh.delete();
                mph = 0;
            end else if (drain_req) begin
                mph = 2;
            end
        end else begin
            if (lane_ready) begin
                void'(mh.pop_front());
                if (mh.size() == 0) mph = 0;
            end
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, ".in_ready"},   32'(in_ready),   32'(mph == 0));
        chk({tag, ".word_valid"}, 32'(word_valid), 32'(mph == 1));
        chk({tag, ".word_data"},  word_data,  mph == 1 ? pack_word() : 32'd0);
        chk({tag, ".word_lanes"}, 32'(word_lanes),
            mph == 1 ? 32'(mh.size()) : 32'd0);
        chk({tag, ".lane_valid"}, 32'(lane_valid), 32'(mph == 2));
        chk({tag, ".lane_data"},  32'(lane_data),
            mph == 2 ? 32'(mh[0]) : 32'd0);
    endtask

    task automatic cyc(input vec_t v);
        reset      = v.rst;
        in_valid   = v.iv;
        in_data    = v.d;
        flush      = v.fl;
        word_ready = v.wr;
        drain_req  = v.dr;
        lane_ready = v.lr;
        @(posedge clk);
        #1;
        model_step();
    endtask

    vec_t       tbl[$];
    logic [7:0] sent[$];
    logic [7:0] got[$];

    initial begin
        // rst iv d fl wr dr lr | ir wv wd wl lv ld
        tbl.push_back(mk(1,0,8'h00,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h11,0,1,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h22,0,1,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h33,0,1,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h44,0,1,0,0, 0,1,32'h11223344,4,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,0,1,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hAA,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hBB,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,1,0,0,0, 0,1,32'hAABB0000,2,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,0,1,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h01,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h02,1,0,0,0, 0,1,32'h01020000,2,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,0,1,1,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,1,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hDE,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hAD,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hBE,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hEF,0,0,0,0, 0,1,32'hDEADBEEF,4,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0, 0,0,32'h0,0,1,8'hDE));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1, 0,0,32'h0,0,1,8'hAD));
        tbl.push_back(mk(0,1,8'h99,1,1,0,0, 0,0,32'h0,0,1,8'hAD));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1, 0,0,32'h0,0,1,8'hBE));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0, 0,0,32'h0,0,1,8'hBE));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1, 0,0,32'h0,0,1,8'hEF));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0, 0,0,32'h0,0,1,8'hEF));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h10,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h20,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h30,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,1,0,0,0, 0,1,32'h10203000,3,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0, 0,0,32'h0,0,1,8'h10));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1, 0,0,32'h0,0,1,8'h20));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1, 0,0,32'h0,0,1,8'h30));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hA1,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hA2,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hA3,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'hA4,0,0,0,0, 0,1,32'hA1A2A3A4,4,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0, 0,0,32'h0,0,1,8'hA1));
        tbl.push_back(mk(0,0,8'h00,0,0,0,1, 0,0,32'h0,0,1,8'hA2));
        tbl.push_back(mk(1,1,8'h55,1,1,1,1, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h01,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h02,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h03,0,0,0,0, 1,0,32'h0,0,0,8'h00));
        tbl.push_back(mk(0,1,8'h04,0,0,0,0, 0,1,32'h01020304,4,0,8'h00));
        tbl.push_back(mk(0,0,8'h00,0,1,0,0, 1,0,32'h0,0,0,8'h00));

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            cyc(tbl[i]);
            chk({tag, ".in_ready"},   32'(in_ready),   32'(tbl[i].ir));
            chk({tag, ".word_valid"}, 32'(word_valid), 32'(tbl[i].wv));
            chk({tag, ".word_data"},  word_data,       tbl[i].wd);
            chk({tag, ".word_lanes"}, 32'(word_lanes), 32'(tbl[i].wl));
            chk({tag, ".lane_valid"}, 32'(lane_valid), 32'(tbl[i].lv));
            chk({tag, ".lane_data"},  32'(lane_data),  32'(tbl[i].ld));
        end

        // Full word under backpressure with extra offered lanes, then a
        // stalling drain that must emit exactly the four packed lanes.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            sent.push_back(b);
            cyc(mk(0,1,b,0,0,0,0, 0,0,0,0,0,0));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(mk(0,1,8'($urandom),0,0,0,0, 0,0,0,0,0,0));
            model_check("stall");
        end
        cyc(mk(0,0,0,0,0,1,0, 0,0,0,0,0,0));
        for (int k = 0; k < 20 && !in_ready; k++) begin
            logic take;
            take = 1'($urandom);
            if (take && lane_valid) got.push_back(lane_data);
            cyc(mk(0,0,0,0,0,0,take, 0,0,0,0,0,0));
        end
        chk("drain.done", 32'(in_ready), 32'd1);
        chk("drain.count", 32'(got.size()), 32'(sent.size()));
        foreach (sent[i])
            if (i < got.size())
                chk($sformatf("drain.lane%0d", i), 32'(got[i]), 32'(sent[i]));

        // Random traffic against the queue model.
        for (int k = 0; k < 3000; k++) begin
            vec_t v;
            v = mk($urandom_range(0, 99) < 2,
                   $urandom_range(0, 99) < 70, 8'($urandom),
                   $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 30,
                   $urandom_range(0, 99) < 25,
                   $urandom_range(0, 99) < 50,
                   0,0,0,0,0,0);
            cyc(v);
            model_check($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
